priority_encoder16to4: RTL and testbench
========================================

PRIORITY_ENCODER16TO4 -- requirements
Module: priority_encoder16to4

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 en  input  1  input vector valid.
REQ-004 in  input  16  bit vector to encode; bit 15 has highest priority.
REQ-005 in_ready  output  1  block can accept a vector this cycle.
REQ-006 D  output  4  index of the highest-priority pending bit.
REQ-007 out_valid  output  1  D, last and none are valid this cycle.
REQ-008 out_ready  input  1  downstream accepts the current beat.
REQ-009 last  output  1  current beat is the final beat for the accepted vector.
REQ-010 none  output  1  the accepted vector was all-zero; D=0 for that beat.

Function
REQ-011 The block SHALL serialize each accepted vector into one beat per set bit, highest index first (the inverse of decoder4to16).
REQ-012 The block SHALL accept a vector on a clock edge only when en && in_ready.
REQ-013 in_ready SHALL equal !out_valid || (out_ready && last), so a new vector can be accepted in the same cycle as the final beat handshake.
REQ-014 The block SHALL hold the remaining bits in a 16-bit pending register, pend, and a zero-beat flag, zflag.
REQ-015 State: IDLE when pend==0 and zflag==0, otherwise EMIT; out_valid = (state==EMIT).
REQ-016 On acceptance, pend SHALL load in, and zflag SHALL load (in==0).
REQ-017 The first beat SHALL be valid the cycle after acceptance (latency 1); no combinational path from in or en to any output.
REQ-018 D SHALL equal the index of the highest set bit of pend, or 0 when zflag=1.
REQ-019 last SHALL be 1 when pend has exactly one bit set or zflag=1; none SHALL equal zflag.
REQ-020 On out_valid && out_ready && !last, the bit pend[D] SHALL clear; the other bits SHALL be kept.
REQ-021 On out_valid && out_ready && last, pend and zflag SHALL clear, unless a new vector is accepted on the same edge, in which case the new vector SHALL load.
REQ-022 While out_valid && !out_ready, D, last, none and pend SHALL hold stable; en is ignored.
REQ-023 An all-zero vector SHALL produce exactly one beat with none=1, last=1, D=0.
REQ-024 Throughput for back-to-back vectors SHALL be popcount(in) beats (min 1) per vector, with no idle cycle between vectors.

Reset
REQ-025 While rst=1: pend=0, zflag=0, out_valid=0, in_ready=1, D=0, last=0, none=0 (and count=0 if configured).
REQ-026 rst asserted mid-vector SHALL discard all pending bits and produce no further beats.
REQ-027 rst SHALL take priority over en and out_ready on the same edge.

Configuration
REQ-028 Macro ENC_COUNT_EN defined: the block SHALL add output count[4:0] giving the number of beats still to be sent including the current one (popcount(pend), or 1 when zflag=1); count=0 when out_valid=0.
REQ-029 Macro ENC_COUNT_EN undefined: port count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset, then in=16'h8001 with en=1 and out_ready=1 held -> beats D=15 (last=0) then D=0 (last=1); in_ready=0 during the first beat.
REQ-031 Accept in=16'h0000 -> one beat with none=1, last=1, D=0 the next cycle, then IDLE.
REQ-032 Accept in=16'h00F0, out_ready=0 for 3 cycles -> D=7 held stable, out_valid=1; then out_ready=1 -> D=7,6,5,4, with last on D=4.
REQ-033 Back-to-back en with 16'h0004 then 16'h0200 -> D=2 (last=1) immediately followed by D=9 (last=1), with no gap cycle.
REQ-034 Accept 16'hFFFF, assert rst after 3 beats -> out_valid=0 the next cycle and in_ready=1; no stale beats after reset release.
REQ-035 With ENC_COUNT_EN defined, accept 16'h0111 -> count=3,2,1 on the beats D=8,4,0.

Source files
------------

// File: rtl/priority_encoder16to4.sv
// Serializing 16-to-4 priority encoder: each accepted vector is emitted as one beat per set bit, MSB first.
// Optional build macro ENC_COUNT_EN adds a count[4:0] output of beats remaining including the current one.
module priority_encoder16to4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] in,
  output logic        in_ready,
  output logic [3:0]  D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        last,
  output logic        none
`ifdef ENC_COUNT_EN
  ,
  output logic [4:0]  count
`endif
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic        zflag_q, zflag_d;

  logic [3:0]  top_idx;
  logic        one_hot;
  logic        accept;
  logic        fire;
  logic        valid_int;
  logic        last_int;

  always_comb begin
    top_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pend_q[i]) top_idx = 4'(i);
    end
  end

  assign one_hot   = (pend_q != 16'd0) && ((pend_q & (pend_q - 16'd1)) == 16'd0);
  assign valid_int = (state_q == EMIT);
  assign last_int  = valid_int && (zflag_q || one_hot);
  assign fire      = valid_int && out_ready;
  assign accept    = en && (!valid_int || (out_ready && last_int));

  // Outputs are forced to their idle values while reset is held, since reset is only sampled on an edge.
  assign out_valid = valid_int && !rst;
  assign in_ready  = rst || !valid_int || (out_ready && last_int);
  assign D         = (rst || zflag_q) ? 4'd0 : top_idx;
  assign last      = last_int && !rst;
  assign none      = zflag_q && !rst;

`ifdef ENC_COUNT_EN
  logic [4:0] pop;

  always_comb begin
    pop = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + {4'd0, pend_q[i]};
    end
  end

  assign count = (rst || !valid_int) ? 5'd0 : (zflag_q ? 5'd1 : pop);
`endif

  always_comb begin
    pend_d  = pend_q;
    zflag_d = zflag_q;
    if (fire) begin
      if (last_int) begin
        pend_d  = 16'd0;
        zflag_d = 1'b0;
      end else begin
        pend_d[top_idx] = 1'b0;
      end
    end
    if (accept) begin
      pend_d  = in;
      zflag_d = (in == 16'd0);
    end
    state_d = ((pend_d != 16'd0) || zflag_d) ? EMIT : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 16'd0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zflag_q <= zflag_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder16to4.sv
// Directed self-checking bench for priority_encoder16to4; count checks run when ENC_COUNT_EN is defined.
module tb_priority_encoder16to4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] in;
  logic        in_ready;
  logic [3:0]  D;
  logic        out_valid;
  logic        out_ready;
  logic        last;
  logic        none;
`ifdef ENC_COUNT_EN
  logic [4:0]  count;
`endif

  int checks;
  int errors;

  priority_encoder16to4 dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last),
    .none      (none)
`ifdef ENC_COUNT_EN
    ,
    .count     (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [3:0] d_exp, input logic last_exp, input logic none_exp);
    checkOutput({tag, ".valid"}, {15'd0, out_valid}, 16'd1);
    checkOutput({tag, ".D"}, {12'd0, D}, {12'd0, d_exp});
    checkOutput({tag, ".last"}, {15'd0, last}, {15'd0, last_exp});
    checkOutput({tag, ".none"}, {15'd0, none}, {15'd0, none_exp});
  endtask

  task automatic applyStimulus(input logic [15:0] vec);
    in = vec;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    in        = 16'd0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst.valid", {15'd0, out_valid}, 16'd0);
    checkOutput("rst.in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("rst.D", {12'd0, D}, 16'd0);
    checkOutput("rst.last", {15'd0, last}, 16'd0);
    checkOutput("rst.none", {15'd0, none}, 16'd0);
`ifdef ENC_COUNT_EN
    checkOutput("rst.count", {11'd0, count}, 16'd0);
`endif
    rst = 1'b0;

    // 8001: two beats, D=15 then D=0
    in = 16'h8001;
    en = 1'b1;
    tick();
    checkBeat("v8001.b0", 4'd15, 1'b0, 1'b0);
    checkOutput("v8001.in_ready", {15'd0, in_ready}, 16'd0);
    en = 1'b0;
    tick();
    checkBeat("v8001.b1", 4'd0, 1'b1, 1'b0);
    checkOutput("v8001.in_ready_last", {15'd0, in_ready}, 16'd1);
    tick();
    checkOutput("v8001.idle", {15'd0, out_valid}, 16'd0);

    // All-zero vector: single none beat
    applyStimulus(16'h0000);
    checkBeat("zero", 4'd0, 1'b1, 1'b1);
    tick();
    checkOutput("zero.idle", {15'd0, out_valid}, 16'd0);
    checkOutput("zero.none_after", {15'd0, none}, 16'd0);

    // 00F0 with a three-cycle stall; en with another vector must be ignored
    out_ready = 1'b0;
    applyStimulus(16'h00F0);
    in = 16'hFFFF;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkBeat("stall", 4'd7, 1'b0, 1'b0);
      checkOutput("stall.in_ready", {15'd0, in_ready}, 16'd0);
      tick();
    end
    en = 1'b0;
    out_ready = 1'b1;
    checkBeat("f0.b0", 4'd7, 1'b0, 1'b0);
    tick();
    checkBeat("f0.b1", 4'd6, 1'b0, 1'b0);
    tick();
    checkBeat("f0.b2", 4'd5, 1'b0, 1'b0);
    tick();
    checkBeat("f0.b3", 4'd4, 1'b1, 1'b0);
    tick();
    checkOutput("f0.idle", {15'd0, out_valid}, 16'd0);

    // Back-to-back 0004 then 0200 with no gap
    applyStimulus(16'h0004);
    in = 16'h0200;
    en = 1'b1;
    checkBeat("b2b.a", 4'd2, 1'b1, 1'b0);
    checkOutput("b2b.in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    en = 1'b0;
    checkBeat("b2b.b", 4'd9, 1'b1, 1'b0);
    tick();
    checkOutput("b2b.idle", {15'd0, out_valid}, 16'd0);

    // FFFF aborted by reset after three beats
    applyStimulus(16'hFFFF);
    checkBeat("ffff.b0", 4'd15, 1'b0, 1'b0);
    tick();
    checkBeat("ffff.b1", 4'd14, 1'b0, 1'b0);
    tick();
    checkBeat("ffff.b2", 4'd13, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("abort.valid", {15'd0, out_valid}, 16'd0);
    checkOutput("abort.in_ready", {15'd0, in_ready}, 16'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort.in_ready_rel", {15'd0, in_ready}, 16'd1);
    tick();
    checkOutput("abort.stale0", {15'd0, out_valid}, 16'd0);
    tick();
    checkOutput("abort.stale1", {15'd0, out_valid}, 16'd0);

    // Reset beats en on the same edge
    rst = 1'b1;
    in  = 16'h1234;
    en  = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    tick();
    checkOutput("rst_vs_en.valid", {15'd0, out_valid}, 16'd0);

`ifdef ENC_COUNT_EN
    applyStimulus(16'h0111);
    checkBeat("cnt.b0", 4'd8, 1'b0, 1'b0);
    checkOutput("cnt.c0", {11'd0, count}, 16'd3);
    tick();
    checkBeat("cnt.b1", 4'd4, 1'b0, 1'b0);
    checkOutput("cnt.c1", {11'd0, count}, 16'd2);
    tick();
    checkBeat("cnt.b2", 4'd0, 1'b1, 1'b0);
    checkOutput("cnt.c2", {11'd0, count}, 16'd1);
    tick();
    checkOutput("cnt.idle", {11'd0, count}, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
